// File: rtl/csr_bank_pkg.sv
// Shared types, CSR address map and mstatus field positions for the
// machine-mode CSR bank.
package csr_bank_pkg;

  localparam int CSR_XLEN = 32;

  typedef logic [11:0] csr_addr_t;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'd0,
    CSR_OP_RW   = 2'd1,
    CSR_OP_RS   = 2'd2,
    CSR_OP_RC   = 2'd3
  } csr_op_t;

  localparam csr_addr_t ISA_CSR_ADDR_MSTATUS   = 12'h300;
  localparam csr_addr_t ISA_CSR_ADDR_MIE       = 12'h304;
  localparam csr_addr_t ISA_CSR_ADDR_MTVEC     = 12'h305;
  localparam csr_addr_t ISA_CSR_ADDR_MSCRATCH  = 12'h340;
  localparam csr_addr_t ISA_CSR_ADDR_MEPC      = 12'h341;
  localparam csr_addr_t ISA_CSR_ADDR_MCAUSE    = 12'h342;
  localparam csr_addr_t ISA_CSR_ADDR_MCYCLE    = 12'hB00;
  localparam csr_addr_t ISA_CSR_ADDR_MINSTRET  = 12'hB02;
  localparam csr_addr_t ISA_CSR_ADDR_MCYCLEH   = 12'hB80;
  localparam csr_addr_t ISA_CSR_ADDR_MINSTRETH = 12'hB82;
  localparam csr_addr_t ISA_CSR_ADDR_CYCLE     = 12'hC00;
  localparam csr_addr_t ISA_CSR_ADDR_INSTRET   = 12'hC02;
  localparam csr_addr_t ISA_CSR_ADDR_CYCLEH    = 12'hC80;
  localparam csr_addr_t ISA_CSR_ADDR_INSTRETH  = 12'hC82;
  localparam csr_addr_t ISA_CSR_ADDR_MHARTID   = 12'hF14;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MSTATUS_MPP_LSB  = 11;

  // New CSR value produced by a read-modify-write instruction.
  function automatic logic [31:0] csr_wr_value(input csr_op_t op,
                                               input logic [31:0] old_val,
                                               input logic [31:0] operand);
    logic [31:0] res;
    case (op)
      CSR_OP_RW: res = operand;
      CSR_OP_RS: res = old_val | operand;
      CSR_OP_RC: res = old_val & ~operand;
      default:   res = old_val;
    endcase
    return res;
  endfunction

  // Architectural view of mstatus: MPP hardwired to machine mode.
  function automatic logic [31:0] mstatus_pack(input logic mie, input logic mpie);
    logic [31:0] res;
    res = 32'h0000_0000;
    res[MSTATUS_MPP_LSB +: 2] = 2'b11;
    res[MSTATUS_MPIE_BIT]     = mpie;
    res[MSTATUS_MIE_BIT]      = mie;
    return res;
  endfunction

  // Direct-mode vector / instruction alignment: low two bits cleared.
  function automatic logic [31:0] align4(input logic [31:0] val);
    return val & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/csr_bank_counter64.sv
// 64-bit free-running counter with independent 32-bit half writes.
// Any write suppresses that cycle's increment for the whole counter.
module csr_counter64
  import csr_bank_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                inc,
  input  logic                wr_lo,
  input  logic                wr_hi,
  input  logic [CSR_XLEN-1:0] data,
  output logic [63:0]         value
);

  logic [63:0] cnt_r;

  // Counter state: reset, then half writes, then increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= 64'h0000_0000_0000_0000;
    end else if (wr_lo || wr_hi) begin
      cnt_r[31:0]  <= wr_lo ? data : cnt_r[31:0];
      cnt_r[63:32] <= wr_hi ? data : cnt_r[63:32];
    end else if (inc) begin
      cnt_r <= cnt_r + 64'd1;
    end
  end

  assign value = cnt_r;

endmodule

// File: rtl/csr_bank.sv
// Machine-mode CSR bank: CSR instruction decode and read-modify-write,
// trap entry / mret side effects on mstatus, mepc and mcause, and the
// mcycle / minstret performance counters.
module csr_bank
  import csr_bank_pkg::*;
#(
  parameter logic [31:0] MHARTID      = 32'h0000_0000,
  parameter logic [31:0] MTVEC_RST    = 32'h0000_0000,
  parameter bit          HAS_MINSTRET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic        req_we,
  input  logic [11:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        illegal,
  input  logic        trap_valid,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic        mret,
  input  logic        retire,
  output logic        mstatus_mie,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o
);

  logic        mst_mie_r;
  logic        mst_mpie_r;
  logic [31:0] mie_r;
  logic [31:0] mtvec_r;
  logic [31:0] mscratch_r;
  logic [31:0] mepc_r;
  logic [31:0] mcause_r;

  logic [63:0] mcycle_s;
  logic [63:0] minstret_s;

  csr_op_t     op_s;
  logic [31:0] read_val_s;
  logic        mapped_s;
  logic        minstret_addr_s;
  logic        illegal_s;
  logic        wr_en_s;
  logic [31:0] wr_val_s;

  assign op_s = csr_op_t'(req_op);

  // Address decode: old value of the selected CSR and whether it exists.
  always_comb begin
    read_val_s      = 32'h0000_0000;
    mapped_s        = 1'b1;
    minstret_addr_s = 1'b0;
    case (addr)
      ISA_CSR_ADDR_MSTATUS:  read_val_s = mstatus_pack(mst_mie_r, mst_mpie_r);
      ISA_CSR_ADDR_MIE:      read_val_s = mie_r;
      ISA_CSR_ADDR_MTVEC:    read_val_s = mtvec_r;
      ISA_CSR_ADDR_MSCRATCH: read_val_s = mscratch_r;
      ISA_CSR_ADDR_MEPC:     read_val_s = mepc_r;
      ISA_CSR_ADDR_MCAUSE:   read_val_s = mcause_r;
      ISA_CSR_ADDR_MCYCLE,
      ISA_CSR_ADDR_CYCLE:    read_val_s = mcycle_s[31:0];
      ISA_CSR_ADDR_MCYCLEH,
      ISA_CSR_ADDR_CYCLEH:   read_val_s = mcycle_s[63:32];
      ISA_CSR_ADDR_MINSTRET: begin
        read_val_s      = minstret_s[31:0];
        minstret_addr_s = 1'b1;
      end
      ISA_CSR_ADDR_MINSTRETH: begin
        read_val_s      = minstret_s[63:32];
        minstret_addr_s = 1'b1;
      end
      ISA_CSR_ADDR_INSTRET:  read_val_s = minstret_s[31:0];
      ISA_CSR_ADDR_INSTRETH: read_val_s = minstret_s[63:32];
      ISA_CSR_ADDR_MHARTID:  read_val_s = MHARTID;
      default:               mapped_s   = 1'b0;
    endcase
  end

  // Fault detection: unmapped CSR, reserved op, write to a read-only CSR,
  // or write to a counter that was configured out.
  always_comb begin
    illegal_s = 1'b0;
    if (req_valid) begin
      illegal_s = !mapped_s
               || (op_s == CSR_OP_NONE)
               || (req_we && (addr[11:10] == 2'b11))
               || (req_we && minstret_addr_s && !HAS_MINSTRET);
    end else begin
      illegal_s = 1'b0;
    end
  end

  assign wr_en_s  = req_valid && req_we && !illegal_s;
  assign wr_val_s = csr_wr_value(op_s, read_val_s, wdata);
  assign illegal  = illegal_s;
  assign rdata    = illegal_s ? 32'h0000_0000 : read_val_s;

  // Trap-sensitive state: trap entry beats mret, which beats a CSR write.
  always_ff @(posedge clk) begin
    if (rst) begin
      mst_mie_r  <= 1'b0;
      mst_mpie_r <= 1'b0;
      mepc_r     <= 32'h0000_0000;
      mcause_r   <= 32'h0000_0000;
    end else if (trap_valid) begin
      mst_mpie_r <= mst_mie_r;
      mst_mie_r  <= 1'b0;
      mepc_r     <= align4(trap_pc);
      mcause_r   <= trap_cause;
    end else if (mret) begin
      mst_mie_r  <= mst_mpie_r;
      mst_mpie_r <= 1'b1;
    end else if (wr_en_s) begin
      case (addr)
        ISA_CSR_ADDR_MSTATUS: begin
          mst_mie_r  <= wr_val_s[MSTATUS_MIE_BIT];
          mst_mpie_r <= wr_val_s[MSTATUS_MPIE_BIT];
        end
        ISA_CSR_ADDR_MEPC:   mepc_r   <= align4(wr_val_s);
        ISA_CSR_ADDR_MCAUSE: mcause_r <= wr_val_s;
        default: ;
      endcase
    end
  end

  // Plain read/write CSRs, unaffected by trap or mret.
  always_ff @(posedge clk) begin
    if (rst) begin
      mie_r      <= 32'h0000_0000;
      mtvec_r    <= MTVEC_RST;
      mscratch_r <= 32'h0000_0000;
    end else if (wr_en_s) begin
      case (addr)
        ISA_CSR_ADDR_MIE:      mie_r      <= wr_val_s;
        ISA_CSR_ADDR_MTVEC:    mtvec_r    <= align4(wr_val_s);
        ISA_CSR_ADDR_MSCRATCH: mscratch_r <= wr_val_s;
        default: ;
      endcase
    end
  end

  csr_counter64 u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .wr_lo (wr_en_s && (addr == ISA_CSR_ADDR_MCYCLE)),
    .wr_hi (wr_en_s && (addr == ISA_CSR_ADDR_MCYCLEH)),
    .data  (wr_val_s),
    .value (mcycle_s)
  );

  generate
    if (HAS_MINSTRET) begin : g_minstret
      csr_counter64 u_minstret (
        .clk   (clk),
        .rst   (rst),
        .inc   (retire),
        .wr_lo (wr_en_s && (addr == ISA_CSR_ADDR_MINSTRET)),
        .wr_hi (wr_en_s && (addr == ISA_CSR_ADDR_MINSTRETH)),
        .data  (wr_val_s),
        .value (minstret_s)
      );
    end else begin : g_no_minstret
      assign minstret_s = 64'h0000_0000_0000_0000;
    end
  endgenerate

  assign mstatus_mie = mst_mie_r;
  assign mtvec_o     = mtvec_r;
  assign mepc_o      = mepc_r;

endmodule

// File: tb/tb_csr_bank.sv
// Self-checking bench for csr_bank: directed scenarios plus randomized
// traffic compared against an architectural model of the CSR file.
module tb_csr_bank;

  localparam logic [31:0] HARTID = 32'h0000_0005;
  localparam logic [31:0] TVEC0  = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_we, trap_valid, mret, retire;
  logic [1:0]  req_op;
  logic [11:0] addr;
  logic [31:0] wdata, trap_cause, trap_pc, rdata, mtvec_o, mepc_o;
  logic        illegal, mstatus_mie;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] last_rd;
  logic        last_ill;

  // architectural model state
  logic        m_mie, m_mpie;
  logic [31:0] m_mie_reg, m_mtvec, m_mscratch, m_mepc, m_mcause;
  logic [63:0] m_cycle, m_instret;

  logic [11:0] addr_tab [19] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                                 12'h342, 12'hB00, 12'hB02, 12'hB80, 12'hB82,
                                 12'hC00, 12'hC02, 12'hC80, 12'hC82, 12'hF14,
                                 12'h7FF, 12'h301, 12'h000, 12'h343};

  csr_bank #(.MHARTID(HARTID), .MTVEC_RST(TVEC0), .HAS_MINSTRET(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
    .req_we(req_we), .addr(addr), .wdata(wdata), .rdata(rdata),
    .illegal(illegal), .trap_valid(trap_valid), .trap_cause(trap_cause),
    .trap_pc(trap_pc), .mret(mret), .retire(retire),
    .mstatus_mie(mstatus_mie), .mtvec_o(mtvec_o), .mepc_o(mepc_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mie = 1'b0; m_mpie = 1'b0;
    m_mie_reg = 32'h0; m_mtvec = TVEC0; m_mscratch = 32'h0;
    m_mepc = 32'h0; m_mcause = 32'h0;
    m_cycle = 64'h0; m_instret = 64'h0;
  endtask

  function automatic void model_read(input logic [11:0] a, output logic mapped,
                                     output logic [31:0] v);
    mapped = 1'b1;
    v = 32'h0;
    case (a)
      12'h300: v = 32'h0000_1800 | (32'(m_mie) << 3) | (32'(m_mpie) << 7);
      12'h304: v = m_mie_reg;
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'hB00, 12'hC00: v = m_cycle[31:0];
      12'hB80, 12'hC80: v = m_cycle[63:32];
      12'hB02, 12'hC02: v = m_instret[31:0];
      12'hB82, 12'hC82: v = m_instret[63:32];
      12'hF14: v = HARTID;
      default: mapped = 1'b0;
    endcase
  endfunction

  // Architectural effect of one clock edge, given the current inputs.
  task automatic model_update(input logic ill);
    logic [31:0] old, nv;
    logic        mapped, wr;
    logic [63:0] cyc_n, ins_n;
    if (rst) begin
      model_reset();
    end else begin
      model_read(addr, mapped, old);
      wr = req_valid && req_we && !ill;
      case (req_op)
        2'd1:    nv = wdata;
        2'd2:    nv = old | wdata;
        default: nv = old & ~wdata;
      endcase
      cyc_n = m_cycle + 64'd1;
      ins_n = m_instret + (retire ? 64'd1 : 64'd0);
      if (wr) begin
        case (addr)
          12'hB00: cyc_n = {m_cycle[63:32], nv};
          12'hB80: cyc_n = {nv, m_cycle[31:0]};
          12'hB02: ins_n = {m_instret[63:32], nv};
          12'hB82: ins_n = {nv, m_instret[31:0]};
          12'h304: m_mie_reg = nv;
          12'h305: m_mtvec = {nv[31:2], 2'b00};
          12'h340: m_mscratch = nv;
          default: ;
        endcase
      end
      if (trap_valid) begin
        m_mepc = {trap_pc[31:2], 2'b00};
        m_mcause = trap_cause;
        m_mpie = m_mie;
        m_mie = 1'b0;
      end else if (mret) begin
        m_mie = m_mpie;
        m_mpie = 1'b1;
      end else if (wr) begin
        case (addr)
          12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
          12'h341: m_mepc = {nv[31:2], 2'b00};
          12'h342: m_mcause = nv;
          default: ;
        endcase
      end
      m_cycle = cyc_n;
      m_instret = ins_n;
    end
  endtask

  // One clock: check combinational response, clock, update model, check state.
  task automatic step(input string tag);
    logic [31:0] exp_rd;
    logic        mapped, exp_ill;
    #1;
    model_read(addr, mapped, exp_rd);
    exp_ill = req_valid && (!mapped || req_op == 2'd0 || (req_we && addr[11:10] == 2'b11));
    if (exp_ill) exp_rd = 32'h0;
    last_rd = rdata;
    last_ill = illegal;
    check_val({tag, "_illegal"}, 64'(illegal), 64'(exp_ill));
    if (req_valid) check_val({tag, "_rdata"}, 64'(rdata), 64'(exp_rd));
    @(posedge clk);
    model_update(exp_ill);
    #1;
    check_val({tag, "_mie_o"}, 64'(mstatus_mie), 64'(m_mie));
    check_val({tag, "_mtvec_o"}, 64'(mtvec_o), 64'(m_mtvec));
    check_val({tag, "_mepc_o"}, 64'(mepc_o), 64'(m_mepc));
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_we = 1'b0;
    addr = 12'h0; wdata = 32'h0; trap_valid = 1'b0; trap_cause = 32'h0;
    trap_pc = 32'h0; mret = 1'b0; retire = 1'b0;
  endtask

  task automatic acc(input string tag, input logic [1:0] op, input logic we,
                     input logic [11:0] a, input logic [31:0] d);
    req_valid = 1'b1; req_op = op; req_we = we; addr = a; wdata = d;
    step(tag);
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [11:0] a);
    acc(tag, 2'd2, 1'b0, a, 32'h0);
  endtask

  initial begin
    int k;
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // counters are zero right after reset; reset values
    rd("rst_mcycle", 12'hB00);      check_val("rst_mcycle_zero", 64'(last_rd), 64'h0);
    rd("rst_mtvec", 12'h305);       check_val("rst_mtvec_val", 64'(last_rd), 64'(TVEC0));
    rd("rst_mstatus", 12'h300);     check_val("rst_mstatus_val", 64'(last_rd), 64'h1800);
    rd("rst_mhartid", 12'hF14);     check_val("rst_mhartid_val", 64'(last_rd), 64'(HARTID));

    // read-modify-write on mscratch
    acc("ms_rw", 2'd1, 1'b1, 12'h340, 32'hDEAD_BEEF);
    acc("ms_rs", 2'd2, 1'b1, 12'h340, 32'h0000_00F0);
    check_val("ms_rs_old", 64'(last_rd), 64'hDEAD_BEEF);
    rd("ms_rd1", 12'h340);          check_val("ms_after_rs", 64'(last_rd), 64'hDEAD_BEFF);
    acc("ms_rc", 2'd3, 1'b1, 12'h340, 32'hFFFF_0000);
    rd("ms_rd2", 12'h340);          check_val("ms_after_rc", 64'(last_rd), 64'h0000_BEFF);

    // illegal accesses
    acc("hart_wr", 2'd1, 1'b1, 12'hF14, 32'h1234_5678);
    check_val("hart_wr_illegal", 64'(last_ill), 64'h1);
    check_val("hart_wr_rdata", 64'(last_rd), 64'h0);
    rd("hart_rs", 12'hF14);
    check_val("hart_rs_legal", 64'(last_ill), 64'h0);
    check_val("hart_rs_val", 64'(last_rd), 64'(HARTID));
    acc("unmapped", 2'd1, 1'b1, 12'h7FF, 32'h1);
    check_val("unmapped_illegal", 64'(last_ill), 64'h1);
    acc("op0", 2'd0, 1'b1, 12'h340, 32'h0);
    check_val("op0_illegal", 64'(last_ill), 64'h1);
    rd("ms_rd3", 12'h340);          check_val("ms_after_illegal", 64'(last_rd), 64'h0000_BEFF);

    // trap entry and mret
    acc("set_mie", 2'd2, 1'b1, 12'h300, 32'h0000_0008);
    check_val("mie_set", 64'(mstatus_mie), 64'h1);
    trap_valid = 1'b1; trap_cause = 32'd11; trap_pc = 32'h0000_0100;
    step("trap");
    trap_valid = 1'b0;
    check_val("trap_mepc", 64'(mepc_o), 64'h100);
    check_val("trap_mie", 64'(mstatus_mie), 64'h0);
    rd("trap_mcause", 12'h342);     check_val("trap_mcause_val", 64'(last_rd), 64'd11);
    rd("trap_mstatus", 12'h300);    check_val("trap_mstatus_val", 64'(last_rd), 64'h1880);
    mret = 1'b1;
    step("mret");
    mret = 1'b0;
    rd("mret_mstatus", 12'h300);    check_val("mret_mstatus_val", 64'(last_rd), 64'h1888);

    // trap beats a simultaneous mepc write
    trap_valid = 1'b1; trap_cause = 32'd2; trap_pc = 32'h0000_0200;
    acc("trap_vs_wr", 2'd1, 1'b1, 12'h341, 32'h0000_0044);
    trap_valid = 1'b0;
    check_val("trap_vs_wr_mepc", 64'(mepc_o), 64'h200);

    // mtvec low bits forced to zero
    acc("mtvec_wr", 2'd1, 1'b1, 12'h305, 32'h0000_1237);
    check_val("mtvec_align", 64'(mtvec_o), 64'h1234);

    // mcycle low-half carry into the high half
    acc("mc_lo", 2'd1, 1'b1, 12'hB00, 32'hFFFF_FFFF);
    acc("mc_hi", 2'd1, 1'b1, 12'hB80, 32'h0);
    step("mc_idle");
    rd("mc_rd_lo", 12'hB00);        check_val("mc_carry_lo", 64'(last_rd), 64'h0);
    rd("mc_rd_hi", 12'hB80);        check_val("mc_carry_hi", 64'(last_rd), 64'h1);

    // full 64-bit wrap
    acc("mw_hi", 2'd1, 1'b1, 12'hB80, 32'hFFFF_FFFF);
    acc("mw_lo", 2'd1, 1'b1, 12'hB00, 32'hFFFF_FFFF);
    rd("mw_rd1", 12'hC80);          check_val("mw_before", 64'(last_rd), 64'hFFFF_FFFF);
    rd("mw_rd2", 12'hC80);          check_val("mw_after", 64'(last_rd), 64'h0);

    // randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      k = $urandom_range(0, 18);
      addr = addr_tab[k];
      req_valid = ($urandom_range(0, 7) != 0);
      req_op = 2'($urandom_range(0, 3));
      req_we = 1'($urandom_range(0, 1));
      wdata = $urandom;
      trap_valid = ($urandom_range(0, 15) == 0);
      trap_cause = $urandom;
      trap_pc = $urandom;
      mret = ($urandom_range(0, 11) == 0);
      retire = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 149) == 0);
      step("rnd");
    end
    idle_inputs();
    step("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/csr_bank.md
CSR_BANK -- requirements
Module: csr_bank

Interface
REQ-001 Parameter MHARTID, default 0, value returned by mhartid.
REQ-002 Parameter MTVEC_RST, default 32'h0000_0000, mtvec reset value.
REQ-003 Parameter HAS_MINSTRET, default 1; 0 removes the minstret/minstreth counter, which then reads 0 and is illegal to write.
REQ-004 clk  in  1  clock.
REQ-005 rst  in  1  reset: synchronous, active-high.
REQ-006 req_valid  in  1  CSR instruction executes this cycle.
REQ-007 req_op  in  2  csr_op_t: RW=1, RS=2, RC=3; 0 reserved, treated as illegal.
REQ-008 req_we  in  1  write intent; 0 for RS/RC with rs1=x0, making the access read-only.
REQ-009 addr  in  12  CSR address.
REQ-010 wdata  in  32  operand (rs1 value or zimm).
REQ-011 rdata  out  32  old CSR value, combinational.
REQ-012 illegal  out  1  combinational; asserted only when req_valid=1 and the access faults.
REQ-013 trap_valid  in  1  trap entry request.
REQ-014 trap_cause  in  32  mcause value to record.
REQ-015 trap_pc  in  32  faulting PC.
REQ-016 mret  in  1  mret executes.
REQ-017 retire  in  1  one instruction retires.
REQ-018 mstatus_mie, mtvec_o, mepc_o  out  1/32/32  live register values.

Function
REQ-019 Mapped RW CSRs: mstatus, mie, mtvec, mscratch, mepc, mcause, mcycle, mcycleh, minstret, minstreth; RO CSRs: mhartid, cycle, cycleh, instret, instreth.
REQ-020 illegal triggers: unmapped addr; req_op=0; req_we=1 with addr[11:10]=2'b11.
REQ-021 An illegal access changes no state; rdata is 0.
REQ-022 Write value: RW gives wdata; RS gives old|wdata; RC gives old&~wdata. The write commits at posedge when req_valid & req_we & ~illegal.
REQ-023 mstatus: only MIE[3] and MPIE[7] are writable; MPP[12:11] reads 2'b11; all other bits read 0.
REQ-024 mtvec and mepc: bits[1:0] are forced to 0 on write and trap (direct mode).
REQ-025 mcycle (64-bit) increments by 1 every cycle and wraps 2^64-1 -> 0.
REQ-026 minstret (64-bit) increments by 1 on each cycle with retire=1.
REQ-027 A CSR write to either counter half overrides that cycle's increment for the whole counter: the written half takes the new value; the other half holds.
REQ-028 Trap entry, one cycle: mepc<=trap_pc, mcause<=trap_cause, MPIE<=MIE, MIE<=0.
REQ-029 mret, one cycle: MIE<=MPIE, MPIE<=1.
REQ-030 Priority is trap_valid > mret > CSR write; a lower-priority write to mstatus/mepc/mcause that cycle is dropped; other CSR writes proceed.
REQ-031 Outputs reflect register state, so updates are visible the cycle after commit.

Reset
REQ-032 On rst, all registers clear to 0 except mtvec<=MTVEC_RST; mstatus reads 32'h0000_1800.
REQ-033 rst overrides trap, mret, write and increment in the same cycle; the counters read 0 in the cycle after reset.

Structure
REQ-034 The shared types package holds csr_addr_t, csr_op_t, every ISA_CSR_ADDR_* constant, and the mstatus bit-index constants.
REQ-035 The sub-module csr_counter64 (64-bit counter with inc, wr_lo, wr_hi and data inputs) is instantiated twice.

Verification
REQ-036 Reset; read mtvec, mstatus, mhartid -> MTVEC_RST, 32'h1800, MHARTID.
REQ-037 RW mscratch=32'hDEAD_BEEF, then RS with 32'h0000_00F0 -> rdata DEADBEEF, new value DEADBEFF; then RC with 32'hFFFF_0000 -> 0000BEFF.
REQ-038 Write to mhartid with req_we=1 -> illegal=1, value unchanged; RS to mhartid with req_we=0 -> illegal=0, rdata=MHARTID; addr 12'h7FF -> illegal=1.
REQ-039 Set MIE=1; trap_valid with cause 11 and pc 32'h100 -> mepc=100, mcause=11, MIE=0, MPIE=1; mret -> MIE=1, MPIE=1.
REQ-040 Write mcycle=32'hFFFF_FFFF with mcycleh=0, then idle one cycle -> mcycle=0, mcycleh=1.
REQ-041 trap_valid together with an RW of mepc=32'h44 -> mepc=trap_pc and the write is dropped.
